bit_serial_alu_seq: RTL

//  Sequencer that drives the 1-bit Alu slice for one WIDTH-bit operation, LSB first, one bit per cycle.

---
 rtl/alu_serial_pkg.sv | 8 +
 rtl/bit_serial_alu_seq_if.sv | 17 +
 rtl/bit_serial_alu_seq_slice.sv | 14 +
 rtl/bit_serial_alu_seq.sv | 70 +++++++
 4 files changed

// File: rtl/alu_serial_pkg.sv
// alu_serial_pkg: op and state encodings shared by the bit-serial ALU sequencer and its slice.
package alu_serial_pkg;
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/bit_serial_alu_seq_if.sv
// bit_serial_alu_seq_if: operand request and result channels of the bit-serial ALU.
interface bit_serial_alu_seq_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_zero;
  modport master (output in_valid, in_a, in_b, in_op, out_ready,
                  input in_ready, out_valid, out_result, out_carry, out_zero);
  modport slave  (input in_valid, in_a, in_b, in_op, out_ready,
                  output in_ready, out_valid, out_result, out_carry, out_zero);
endinterface

// File: rtl/bit_serial_alu_seq_slice.sv
// bit_serial_alu_seq_slice: 1-bit ALU slice; the full-adder carry is produced for every op.
module bit_serial_alu_seq_slice
  import alu_serial_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       y,
  output logic       cout
);
  assign cout = (a & b) | (cin & (a ^ b));
  assign y = op == OP_AND ? a & b : op == OP_OR ? a | b : a ^ b ^ cin;
endmodule

// File: rtl/bit_serial_alu_seq.sv
// bit_serial_alu_seq: feeds one WIDTH-bit operation LSB-first through the 1-bit slice
// and presents the assembled result, carry and zero flag with valid/ready handshakes.
module bit_serial_alu_seq
  import alu_serial_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic reset_n,
  bit_serial_alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, result_q;
  logic [1:0] op_q;
  logic carry_q, out_carry_q, zero_q, y, cout, last;
  logic [CW-1:0] cnt;
  assign last = cnt == CW'(WIDTH);
  bit_serial_alu_seq_slice u_slice (
    .a(a_sh[0]), .b(b_sh[0]), .cin(carry_q),
    .op(op_q[1] ? OP_ADD : op_q), .y(y), .cout(cout)
  );
  always_comb begin
    state_n = state;
    state_n = state == S_IDLE ? (bus.in_valid ? S_RUN : S_IDLE)
            : state == S_RUN  ? (last ? S_DONE : S_RUN)
            : (bus.out_ready ? S_IDLE : S_DONE);
  end
  // Counting to WIDTH (not WIDTH-1) leaves one extra RUN cycle that registers the outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      res_sh      <= '0;
      op_q        <= '0;
      carry_q     <= 1'b0;
      cnt         <= '0;
      result_q    <= '0;
      out_carry_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && bus.in_valid) begin
        a_sh    <= bus.in_a;
        b_sh    <= bus.in_op == OP_SUB ? ~bus.in_b : bus.in_b;
        op_q    <= bus.in_op;
        carry_q <= bus.in_op == OP_SUB;
        cnt     <= '0;
      end
      if (state == S_RUN && !last) begin
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        res_sh  <= {y, res_sh[WIDTH-1:1]};
        carry_q <= cout;
        cnt     <= cnt + CW'(1);
      end
      if (state == S_RUN && last) begin
        result_q    <= res_sh;
        out_carry_q <= op_q[1] & carry_q;
        zero_q      <= ~|res_sh;
      end
    end
  end
  assign bus.in_ready   = state == S_IDLE;
  assign bus.out_valid  = state == S_DONE;
  assign bus.out_result = result_q;
  assign bus.out_carry  = out_carry_q;
  assign bus.out_zero   = zero_q;
endmodule
